uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter, the transmit-side counterpart of UART_Rx in the AES-over-UART path. Ciphertext bytes go in, framed serial goes out.
- Bytes are accepted through a valid/ready handshake into a small FIFO.
- Each byte is serialised as 1 start bit (0), DATA_BITS data bits LSB-first, and 1 stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks, which matches UART_Rx's 16x oversampling.

Parameters:
- CLKS_PER_BIT, 16: clocks per serial bit; legal values are 2 or more.
- DATA_BITS, 8: data bits per frame.
- FIFO_DEPTH, 4: byte-buffer depth; must be a power of two, 2 or more.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  transmit enable; when low, no new frame is started.
- data_in  input  DATA_BITS  byte to transmit.
- valid  input  1  data_in is valid this cycle.
- ready  output  1  FIFO can accept a byte; transfer occurs on valid && ready at a rising edge.
- out  output  1  serial line, registered, idles high.
- busy  output  1  a frame is in progress (START through STOP).
- done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - out=1, busy=0, done=0, ready=1.
  - FIFO is flushed and the FSM goes to IDLE.
  - A reset mid-frame truncates the frame: out is 1 on the cycle after the reset edge.
- FIFO:
  - ready = !full, independent of en.
  - A push is ignored when full.
  - Simultaneous push and pop leaves the count unchanged; an empty FIFO is never popped.
  - Pointers wrap modulo FIFO_DEPTH; the count is one bit wider than the pointers.
- FSM states: IDLE, START, DATA, STOP. A baud counter bcnt runs 0..CLKS_PER_BIT-1; a bit index runs 0..DATA_BITS-1.
  - IDLE: out=1, busy=0. If en && FIFO non-empty: pop into the shift register, clear bcnt, go to START.
  - START: out=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
  - DATA: out=shift[0] for CLKS_PER_BIT cycles. On bcnt wrap, shift right and increment the index; after index DATA_BITS-1, go to STOP.
  - STOP: out=1 for CLKS_PER_BIT cycles. On the final cycle, done=1. Then:
    - if en && FIFO non-empty: pop and go directly to START, with no idle gap;
    - otherwise go to IDLE.
- en deasserted mid-frame: the current frame completes normally, and no further frame starts until en=1.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1, and out=0 from edge N+2.
- Frame length: exactly (DATA_BITS+2)*CLKS_PER_BIT cycles, or 160 cycles at the defaults.
- busy is registered and is high for exactly the frame cycles.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and drives the even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles.
  - The frame grows to (DATA_BITS+3)*CLKS_PER_BIT cycles.
- Undefined: there is no PARITY state and the frame is as specified above.

Decomposition:
- Package uart_pkg holds:
  - the tx state enum (IDLE/START/DATA/STOP/PARITY);
  - the IDLE_LEVEL=1 and START_LEVEL=0 constants;
  - the default CLKS_PER_BIT and DATA_BITS.
- Sub-module uart_tx_fifo, a synchronous FIFO with push/pop/full/empty, is instantiated once. The FSM and baud counter stay in uart_tx.

Test Plan:
- Send 0x55 with defaults:
  - out holds 0 for 16 cycles, then 1,0,1,0,1,0,1,0 (16 cycles each), then 1 for 16 cycles;
  - done pulses once, 160 cycles after out falls; busy is high for exactly 160 cycles.
- Send 0xA3 → data bits on out are 1,1,0,0,0,1,0,1 (LSB first).
- Push 5 bytes back-to-back from reset:
  - ready drops after the 4th accept;
  - the 5th byte is accepted once the first pop occurs;
  - 5 contiguous 160-cycle frames follow, with no idle cycle between STOP and START;
  - 5 done pulses.
- Drop en during frame 1 with 2 bytes queued:
  - frame 1 completes and done pulses;
  - out stays 1 and busy stays 0 while en=0;
  - the next frame starts 1 cycle after en rises.
- Assert rst for 1 cycle mid-DATA with bytes queued → out=1, busy=0, ready=1 next cycle; no further frames.
- Loopback into UART_Rx, sending 0x00, 0xFF, 0x3C → UART_Rx out matches each byte, done pulses, err=0. With UART_TX_PARITY_EN, 0x07 yields parity bit 1 and a 176-cycle frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path: tx FSM state encoding,
// line levels and default frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int DEFAULT_FIFO_DEPTH   = 4;

  // Counter width for a range of v values; never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream valid/ready handshake into the UART transmitter.
// Transfer happens on a rising edge with valid && ready.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) ();

  logic [DATA_BITS-1:0] data_in;
  logic                 valid;
  logic                 ready;

  modport master (
    output data_in,
    output valid,
    input  ready
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the UART transmitter. The head entry is
// visible on dout before pop, so the FSM can load its shift register on the pop edge.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_BITS,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2_min1(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  assign dout = mem[rd_ptr_reg];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes framed as start, DATA_BITS data (LSB
// first), optional even parity (UART_TX_PARITY_EN) and stop, CLKS_PER_BIT clocks per bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  uart_tx_if.slave  bus,
  output logic      out,
  output logic      busy,
  output logic      done
);

  localparam int BW = clog2_min1(CLKS_PER_BIT);
  localparam int IW = clog2_min1(DATA_BITS);
  localparam logic [BW-1:0] BCNT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  tx_state_t            state_reg, state_next;
  logic [BW-1:0]        bcnt_reg, bcnt_next;
  logic [IW-1:0]        idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 out_reg, out_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
`ifdef UART_TX_PARITY_EN
  logic                 parity_reg, parity_next;
`endif

  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 can_start;

  assign bus.ready = !fifo_full;
  assign push      = bus.valid && bus.ready;
  assign bit_end   = (bcnt_reg == BCNT_LAST);
  assign can_start = en && !fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.data_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register; serial outputs are registered from the current state, so
  // the line lags the FSM by exactly one cycle for every frame position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      bcnt_reg   <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      out_reg    <= IDLE_LEVEL;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      bcnt_reg   <= bcnt_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      out_reg    <= out_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // Next-state logic. A pop in STOP chains straight into START with no idle gap.
  always_comb begin
    state_next  = state_reg;
    bcnt_next   = bcnt_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
    pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    if (state_reg != IDLE) begin
      bcnt_next = bit_end ? '0 : bcnt_reg + BW'(1);
    end
    case (state_reg)
      IDLE: begin
        if (can_start) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          bcnt_next  = '0;
          state_next = START;
`ifdef UART_TX_PARITY_EN
          parity_next = ^fifo_dout;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          idx_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          idx_next   = idx_reg + IW'(1);
          if (idx_reg == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (can_start) begin
            pop        = 1'b1;
            shift_next = fifo_dout;
            state_next = START;
`ifdef UART_TX_PARITY_EN
            parity_next = ^fifo_dout;
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        bcnt_next  = '0;
      end
    endcase
  end

  // Output decode. done is raised on the last STOP count so that, once
  // registered, it lines up with the final cycle of the stop bit on the line.
  always_comb begin
    out_next  = IDLE_LEVEL;
    busy_next = 1'b1;
    done_next = 1'b0;
    case (state_reg)
      IDLE:   busy_next = 1'b0;
      START:  out_next  = START_LEVEL;
      DATA:   out_next  = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: out_next  = parity_reg;
`endif
      STOP:   done_next = bit_end;
      default: busy_next = 1'b0;
    endcase
  end

  assign out  = out_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes are queued, and a line monitor
// decodes every frame and compares it position by position against the queue head.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DB + 3;
`else
  localparam int NBITS = DB + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic out, busy, done;

  uart_tx_if #(.DATA_BITS(DB)) bus ();

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .bus  (bus),
    .out  (out),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected line level for bit slot k of a frame carrying byte b.
  function automatic logic exp_level(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= DB) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == DB + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  logic [7:0] sb[$];
  bit         in_frame = 1'b0;
  bit         had_frame = 1'b0;
  int         frames = 0, done_cnt = 0, idle_cnt = 0, gap_sum = 0, fall_cyc = 0;
  int         accept_cyc = 0;

  // Line monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    int pos, k, bad, busy_bad, done_bad;
    logic [7:0] exp_b, rx_b;
    pos = 0; bad = 0; busy_bad = 0; done_bad = 0; exp_b = '0; rx_b = '0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (rst) begin
        in_frame = 1'b0;
        idle_cnt = 0;
      end else begin
        if (!in_frame) begin
          if (out === 1'b0) begin
            in_frame = 1'b1;
            pos = 0; bad = 0; busy_bad = 0; done_bad = 0; rx_b = '0;
            fall_cyc = cyc;
            if (had_frame) gap_sum += idle_cnt;
            had_frame = 1'b1;
            idle_cnt = 0;
            check("sb_nonempty", (sb.size() != 0) ? 1 : 0, 1);
            exp_b = (sb.size() != 0) ? sb.pop_front() : 8'h00;
          end else begin
            idle_cnt++;
          end
        end
        if (in_frame) begin
          k = pos / CPB;
          if (out !== exp_level(exp_b, k)) bad++;
          if (busy !== 1'b1) busy_bad++;
          if (done !== (pos == FRAME - 1)) done_bad++;
          if (k >= 1 && k <= DB && (pos % CPB) == CPB / 2) rx_b[k-1] = out;
          pos++;
          if (pos == FRAME) begin
            $display("[TB] frame %0d: expected 0x%02h received 0x%02h at cycle %0d", frames, exp_b, rx_b, cyc);
            check("rx_byte", rx_b, exp_b);
            check("frame_bits", bad, 0);
            check("busy_in_frame", busy_bad, 0);
            check("done_position", done_bad, 0);
            frames++;
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int t = 0;
    @(negedge clk); #1;
    while (bus.ready !== 1'b1 && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    check("push_ready", bus.ready, 1);
    if (bus.ready === 1'b1) begin
      bus.valid   = 1'b1;
      bus.data_in = b;
      @(posedge clk); #1;
      accept_cyc = cyc;
      sb.push_back(b);
      bus.valid = 1'b0;
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames < n && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    check("frame_count", frames, n);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    int f0, d0, e, t, viol;
    logic [7:0] burst [5];
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44; burst[4] = 8'h5A;
    bus.valid   = 1'b0;
    bus.data_in = '0;

    // Reset values while rst is held.
    idle_cycles(3);
    check("rst_out", out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", bus.ready, 1);
    rst = 1'b0;

    // Single 0x55 frame and push-to-start latency.
    en = 1'b1;
    push(8'h55);
    e = accept_cyc;
    wait_frames(1, FRAME + 50);
    check("start_latency", fall_cyc - e, 2);

    push(8'hA3);
    wait_frames(2, FRAME + 50);

    // Fill the FIFO with en low, then release: the fifth byte waits for the first pop.
    en = 1'b0;
    f0 = frames;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) push(burst[i]);
    check("full_ready", bus.ready, 0);
    had_frame = 1'b0;
    gap_sum   = 0;
    idle_cycles(1);
    en = 1'b1;
    e  = cyc;
    push(burst[4]);
    check("fifth_accept", accept_cyc - e, 2);
    wait_frames(f0 + 5, 5 * FRAME + 100);
    check("b2b_gap", gap_sum, 0);
    check("done_pulses", done_cnt - d0, 5);

    // Drop en mid-frame with two bytes queued.
    f0 = frames;
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    idle_cycles(60);
    en = 1'b0;
    wait_frames(f0 + 1, FRAME + 50);
    viol = 0;
    repeat (100) begin
      @(negedge clk); #1;
      if (out !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("en_low_idle", viol, 0);
    check("en_low_frames", frames, f0 + 1);
    en = 1'b1;
    e  = cyc;
    t  = 0;
    while (!in_frame && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    check("en_resume", fall_cyc - e, 2);
    wait_frames(f0 + 3, 2 * FRAME + 50);

    // One-cycle reset in the middle of DATA with bytes still queued.
    f0 = frames;
    push(8'hE1);
    push(8'hE2);
    push(8'hE3);
    idle_cycles(56);
    rst = 1'b1;
    idle_cycles(1);
    check("midrst_out", out, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ready", bus.ready, 1);
    rst = 1'b0;
    sb.delete();
    viol = 0;
    repeat (400) begin
      @(negedge clk); #1;
      if (out !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("midrst_quiet", viol, 0);
    check("midrst_frames", frames, f0);

    // Loopback bytes decoded by the monitor's receiver.
    f0 = frames;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
`ifdef UART_TX_PARITY_EN
    push(8'h07);
    wait_frames(f0 + 4, 4 * FRAME + 100);
`else
    wait_frames(f0 + 3, 3 * FRAME + 100);
`endif
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
